mem_stage_lsu: RTL

//   MEM pipeline stage, directly downstream of the EX/MEM register.

---
 rtl/mem_stage_lsu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage. It issues one load or store at a time
// over a req/ack data bus, stalls upstream while the access is outstanding,
// and registers write-back data, index and write enable toward MEM/WB.
// Optional feature macro: MEM_SUBWORD_EN enables byte/half accesses (lane
// enables, store replication, load lane extract with sign/zero extension).
// Without the macro every access is a full word.
module mem_stage_lsu #(
    parameter int ADDR_W   = 32,
    parameter int WB_REG_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic [31:0]         ex_alu_result,
    input  logic [31:0]         ex_store_data,
    input  logic [WB_REG_W-1:0] ex_wb_reg,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic [1:0]          ex_size,
    input  logic                ex_unsigned,
    output logic                mem_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_be,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic                wb_valid,
    output logic [31:0]         wb_data,
    output logic [WB_REG_W-1:0] wb_reg,
    output logic                wb_reg_write
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                r_state;
    logic                  r_is_load;
    logic [WB_REG_W-1:0]   r_pend_reg;
    logic                  r_pend_we;

    logic                  w_memop;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ldata;

    // A set mem_write wins over mem_read, so the illegal read+write combo is a store
    assign w_memop = ex_mem_read | ex_mem_write;

    // Stall the issue cycle of a memory op and every BUSY cycle until ack arrives
    assign mem_stall = (r_state == IDLE) ? (ex_valid & w_memop) : ~mem_ack;

`ifdef MEM_SUBWORD_EN
    logic [1:0] r_size;
    logic       r_uns;
    logic [7:0] w_lbyte;
    logic [15:0] w_lhalf;

    // Remember access size/sign for formatting the returning load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size <= 2'b00;
            r_uns  <= 1'b0;
        end else if (r_state == IDLE && ex_valid && w_memop) begin
            r_size <= ex_size;
            r_uns  <= ex_unsigned;
        end
    end

    // Store lane enables and replicated write data by access size
    always_comb begin
        w_be    = 4'hF;
        w_wdata = ex_store_data;
        case (ex_size)
            2'b00: begin
                w_be    = 4'b0001 << ex_alu_result[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = ex_alu_result[1] ? 4'hC : 4'h3;
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane from read data and extend it
    always_comb begin
        w_lbyte = mem_rdata[8*mem_addr[1:0] +: 8];
        w_lhalf = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_ldata = {{24{~r_uns & w_lbyte[7]}}, w_lbyte};
            2'b01:   w_ldata = {{16{~r_uns & w_lhalf[15]}}, w_lhalf};
            default: w_ldata = mem_rdata;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^{ex_size, ex_unsigned};
    assign w_be     = 4'hF;
    assign w_wdata  = ex_store_data;
    assign w_ldata  = mem_rdata;
`endif

    // IDLE/BUSY control with registered bus and write-back outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_is_load    <= 1'b0;
            r_pend_reg   <= '0;
            r_pend_we    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= 4'h0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_reg       <= '0;
            wb_reg_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ex_valid && w_memop) begin
                        r_state    <= BUSY;
                        r_is_load  <= ~ex_mem_write;
                        r_pend_reg <= ex_wb_reg;
                        r_pend_we  <= ex_reg_write & ~ex_mem_write;
                        mem_req    <= 1'b1;
                        mem_we     <= ex_mem_write;
                        mem_addr   <= ex_alu_result[ADDR_W-1:0];
                        mem_wdata  <= w_wdata;
                        mem_be     <= w_be;
                        wb_valid   <= 1'b0;
                    end else if (ex_valid) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ex_alu_result;
                        wb_reg       <= ex_wb_reg;
                        wb_reg_write <= ex_reg_write;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        r_state      <= IDLE;
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_reg       <= r_pend_reg;
                        wb_reg_write <= r_pend_we;
                        // Stores report their effective address as data
                        wb_data      <= r_is_load ? w_ldata : 32'(mem_addr);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
